// File: rtl/stream_tile_compositor.sv
// Per-tile sprite compositor: depth/transparency-resolved span writes into a
// TILE_W x TILE_H color/depth store, row-sequential clear, raster readout.
module stream_tile_compositor #(
    parameter int unsigned TILE_W  = 16,
    parameter int unsigned TILE_H  = 2,
    parameter int unsigned COLOR_W = 8,
    parameter int unsigned DEPTH_W = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear_req,
    input  logic                        rd_start,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [$clog2(TILE_H)-1:0]   s_row,
    input  logic [$clog2(TILE_W)-1:0]   s_start_x,
    input  logic [DEPTH_W-1:0]          s_depth,
    input  logic                        s_mode,
    input  logic [TILE_W*COLOR_W-1:0]   s_data,
    output logic                        o_valid,
    input  logic                        o_ready,
    output logic [COLOR_W-1:0]          o_color,
    output logic [$clog2(TILE_W)-1:0]   o_x,
    output logic [$clog2(TILE_H)-1:0]   o_y,
    output logic                        o_last,
    output logic                        busy
);

    localparam int unsigned XW   = $clog2(TILE_W);
    localparam int unsigned YW   = $clog2(TILE_H);
    localparam int unsigned IW   = XW + YW;
    localparam int unsigned NPIX = TILE_W * TILE_H;

    typedef enum logic [1:0] {IDLE, CLEAR, READOUT} state_t;

    state_t             state, state_nxt;
    logic [YW-1:0]      row_cnt;
    logic [IW-1:0]      pix_idx;
    logic               span_fire;
    logic               in_rd;

    logic [COLOR_W-1:0] color_mem [TILE_H][TILE_W];
    logic [DEPTH_W-1:0] depth_mem [TILE_H][TILE_W];

    logic [TILE_W-1:0]  wr_en;
    logic [COLOR_W-1:0] wr_color [TILE_W];
    logic [XW-1:0]      lane;
    logic [COLOR_W-1:0] lane_val;
    logic [COLOR_W:0]   sum;

    assign span_fire = s_valid && s_ready;
    assign in_rd     = (state == READOUT);

    // Lane n feeds pixel x = s_start_x + n; lanes past the tile edge never map.
    always_comb begin
        wr_en    = '0;
        lane     = '0;
        lane_val = '0;
        sum      = '0;
        for (int unsigned x = 0; x < TILE_W; x++) begin
            lane        = XW'(x) - s_start_x;
            lane_val    = s_data[lane*COLOR_W +: COLOR_W];
            sum         = {1'b0, color_mem[s_row][x]} + {1'b0, lane_val};
            wr_en[x]    = span_fire && (XW'(x) >= s_start_x)
                          && (s_depth >= depth_mem[s_row][x])
                          && ((s_depth == '0) || (lane_val != '0));
            wr_color[x] = s_mode ? (sum[COLOR_W] ? '1 : sum[COLOR_W-1:0]) : lane_val;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned y = 0; y < TILE_H; y++) begin
                for (int unsigned x = 0; x < TILE_W; x++) begin
                    color_mem[y][x] <= '0;
                    depth_mem[y][x] <= '0;
                end
            end
        end else if (state == CLEAR) begin
            for (int unsigned x = 0; x < TILE_W; x++) begin
                color_mem[row_cnt][x] <= '0;
                depth_mem[row_cnt][x] <= '0;
            end
        end else begin
            for (int unsigned x = 0; x < TILE_W; x++) begin
                if (wr_en[x]) begin
                    color_mem[s_row][x] <= wr_color[x];
                    depth_mem[s_row][x] <= s_depth;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            row_cnt <= '0;
            pix_idx <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    row_cnt <= '0;
                    pix_idx <= '0;
                end
                CLEAR:   row_cnt <= row_cnt + 1'b1;
                READOUT: if (o_ready) pix_idx <= pix_idx + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        o_valid   = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                s_ready = !clear_req && !rd_start;
                if (clear_req)     state_nxt = CLEAR;
                else if (rd_start) state_nxt = READOUT;
            end
            CLEAR: begin
                if (row_cnt == YW'(TILE_H - 1)) state_nxt = IDLE;
            end
            READOUT: begin
                o_valid = 1'b1;
                if (o_ready && o_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign o_x     = in_rd ? pix_idx[XW-1:0] : '0;
    assign o_y     = in_rd ? pix_idx[IW-1:XW] : '0;
    assign o_color = in_rd ? color_mem[pix_idx[IW-1:XW]][pix_idx[XW-1:0]] : '0;
    assign o_last  = in_rd && (pix_idx == IW'(NPIX - 1));

endmodule

// File: tb/tb_stream_tile_compositor.sv
// Scoreboard bench for stream_tile_compositor at default 16x2x8x8 geometry.
module tb_stream_tile_compositor;

    localparam int TW = 16;
    localparam int TH = 2;

    logic         clk = 1'b0;
    logic         reset, clear_req, rd_start, s_valid, s_ready, s_mode;
    logic         o_valid, o_ready, o_last, busy;
    logic [0:0]   s_row, o_y;
    logic [3:0]   s_start_x, o_x;
    logic [7:0]   s_depth, o_color;
    logic [127:0] s_data;

    always #5 clk = ~clk;

    stream_tile_compositor #(.TILE_W(16), .TILE_H(2), .COLOR_W(8), .DEPTH_W(8)) dut (
        .clk(clk), .reset(reset), .clear_req(clear_req), .rd_start(rd_start),
        .s_valid(s_valid), .s_ready(s_ready), .s_row(s_row), .s_start_x(s_start_x),
        .s_depth(s_depth), .s_mode(s_mode), .s_data(s_data),
        .o_valid(o_valid), .o_ready(o_ready), .o_color(o_color), .o_x(o_x),
        .o_y(o_y), .o_last(o_last), .busy(busy)
    );

    typedef struct packed {
        logic [7:0] color;
        logic [3:0] x;
        logic [0:0] y;
        logic       last;
    } beat_t;

    beat_t      exp_q[$];
    beat_t      held, e;
    logic       stalled = 1'b0;
    logic [7:0] mdl [TH][TW];
    int         checks = 0;
    int         failures = 0;
    int         beat_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected beat per accepted output, and checks hold during stalls.
    always @(negedge clk) begin
        if (reset) begin
            stalled = 1'b0;
        end else begin
            if (stalled)
                check("stall_hold", 32'({o_valid, o_color, o_x, o_y, o_last}), 32'({1'b1, held}));
            if (o_valid && o_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=(%0d,%0d) expected=none", o_x, o_y);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_color", 32'(o_color), 32'(e.color));
                    check("beat_x", 32'(o_x), 32'(e.x));
                    check("beat_y", 32'(o_y), 32'(e.y));
                    check("beat_last", 32'(o_last), 32'(e.last));
                end
                beat_cnt++;
            end
            stalled = o_valid && !o_ready;
            held    = {o_color, o_x, o_y, o_last};
        end
    end

    task automatic span(input logic row, input logic [3:0] sx, input logic [7:0] d,
                        input logic m, input logic [127:0] data);
        s_valid = 1'b1; s_row = row; s_start_x = sx; s_depth = d; s_mode = m; s_data = data;
        #1;
        check("span_s_ready", 32'(s_ready), 32'd1);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic zero_model();
        for (int y = 0; y < TH; y++)
            for (int x = 0; x < TW; x++)
                mdl[y][x] = 8'h00;
    endtask

    // pat bit k = o_ready on cycle k mod 4; abort_at > 0 asserts reset after that many beats.
    task automatic readout(input logic [3:0] pat, input int abort_at, input bit spam);
        int         cyc;
        logic [1:0] ph;
        for (int i = 0; i < TW*TH; i++)
            exp_q.push_back(beat_t'{color: mdl[i/TW][i%TW], x: 4'(i%TW), y: 1'(i/TW),
                                    last: (i == TW*TH-1)});
        beat_cnt = 0;
        rd_start = 1'b1;
        o_ready  = pat[0];
        #1;
        check("rd_start_s_ready", 32'(s_ready), 32'd0);
        @(posedge clk); #1;
        rd_start = 1'b0;
        check("rd_o_valid", 32'(o_valid), 32'd1);
        check("rd_busy", 32'(busy), 32'd1);
        if (spam) begin
            s_row = 1'b0; s_start_x = 4'd0; s_depth = 8'hFF; s_mode = 1'b0; s_data = {16{8'hEE}};
        end
        cyc = 0;
        while (beat_cnt < TW*TH && cyc < 400 && !(abort_at > 0 && beat_cnt >= abort_at)) begin
            ph = 2'(cyc);
            o_ready = pat[ph];
            if (spam) begin
                s_valid = 1'b1;
                #1;
                check("rd_span_blocked", 32'(s_ready), 32'd0);
            end
            @(posedge clk); #1;
            cyc++;
        end
        s_valid = 1'b0;
        o_ready = 1'b0;
        if (abort_at > 0) begin
            check("abort_beats", 32'(beat_cnt), 32'(abort_at));
            reset = 1'b1;
            #1;
            check("abort_o_valid", 32'(o_valid), 32'd0);
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_o_color", 32'(o_color), 32'd0);
            exp_q.delete();
            zero_model();
            @(posedge clk); #1;
            reset = 1'b0;
        end else begin
            check("rd_beats", 32'(beat_cnt), 32'(TW*TH));
            check("rd_done_busy", 32'(busy), 32'd0);
            check("rd_done_o_valid", 32'(o_valid), 32'd0);
            if (pat == 4'b1111) check("rd_cycles", 32'(cyc), 32'(TW*TH));
        end
        check("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; clear_req = 1'b0; rd_start = 1'b0; s_valid = 1'b0; o_ready = 1'b0;
        s_row = '0; s_start_x = '0; s_depth = '0; s_mode = 1'b0; s_data = '0;
        zero_model();
        repeat (3) @(posedge clk);
        #1;
        check("in_reset_o_valid", 32'(o_valid), 32'd0);
        check("in_reset_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        #1;
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_outs", 32'({o_valid, o_color, o_x, o_y, o_last, busy}), 32'd0);
        @(posedge clk); #1;

        readout(4'b1111, 0, 1'b0);

        span(1'b0, 4'd4, 8'd5, 1'b0, {16{8'h11}});
        span(1'b0, 4'd0, 8'd3, 1'b0, {16{8'h22}});
        for (int x = 0; x < 4; x++)  mdl[0][x] = 8'h22;
        for (int x = 4; x < TW; x++) mdl[0][x] = 8'h11;
        readout(4'b1111, 0, 1'b0);

        span(1'b1, 4'd0, 8'd5, 1'b0, {120'h0, 8'h33});
        mdl[1][0] = 8'h33;
        span(1'b1, 4'd0, 8'd9, 1'b0, '0);
        span(1'b1, 4'd5, 8'd0, 1'b0, {120'h0, 8'h44});
        span(1'b1, 4'd5, 8'd0, 1'b0, '0);
        span(1'b1, 4'd10, 8'd7, 1'b0, {120'h0, 8'hF0});
        span(1'b1, 4'd10, 8'd7, 1'b1, {120'h0, 8'h20});
        mdl[1][10] = 8'hFF;
        span(1'b1, 4'd12, 8'd2, 1'b0, {120'h0, 8'h10});
        span(1'b1, 4'd12, 8'd2, 1'b1, {120'h0, 8'h05});
        mdl[1][12] = 8'h15;
        span(1'b0, 4'd15, 8'd6, 1'b0, {16{8'h66}});
        mdl[0][15] = 8'h66;
        readout(4'b1001, 0, 1'b1);
        readout(4'b1111, 0, 1'b0);

        clear_req = 1'b1; rd_start = 1'b1; s_valid = 1'b1;
        s_row = 1'b0; s_start_x = 4'd0; s_depth = 8'hFF; s_mode = 1'b0; s_data = {16{8'h77}};
        #1;
        check("clr_s_ready", 32'(s_ready), 32'd0);
        @(posedge clk); #1;
        clear_req = 1'b0; rd_start = 1'b0; s_valid = 1'b0;
        n = 0;
        while (busy && n < 10) begin
            check("clr_busy_s_ready", 32'(s_ready), 32'd0);
            n++;
            @(posedge clk); #1;
        end
        check("clr_cycles", 32'(n), 32'd2);
        check("clr_o_valid", 32'(o_valid), 32'd0);
        zero_model();
        readout(4'b1111, 0, 1'b0);

        span(1'b0, 4'd0, 8'd1, 1'b0, {16{8'h5A}});
        for (int x = 0; x < TW; x++) mdl[0][x] = 8'h5A;
        readout(4'b1111, 10, 1'b0);
        readout(4'b1111, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
